thumb_encoder: RTL

Encodes structured operation requests into the 16-bit Thumb instruction words that the decode stage accepts, and writes them sequentially into instruction memory. Used by the test/boot loader path to build programs in hardware without an external assembler. Request side has a valid/ready handshake. Memory side is a one-cycle write strobe with an auto-incrementing address.

---
 rtl/thumb_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/thumb_encoder.sv
// rtl/thumb_encoder.sv - Thumb instruction encoder writing sequential words into instruction memory
// Optional immediate/condition range checking is enabled by defining THUMB_ENC_RANGE_CHECK_EN.
module thumb_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rewind,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [2:0]        req_rd,
  input  logic [2:0]        req_rn,
  input  logic [2:0]        req_rm,
  input  logic [10:0]       req_imm,
  input  logic [3:0]        req_cond,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [15:0]         wdata_q;
  logic [ADDR_W:0]     count_q;
  logic                full_q;
  logic                err_q;
  logic [1:0]          err_code_q;

  logic [15:0]         enc_word;
  logic [1:0]          enc_err;
  logic                accept;
  logic                accept_ok;
  logic                accept_bad;

  assign req_ready  = (state_q == ST_RUN) && !rewind;
  assign accept     = req_valid && req_ready;
  assign accept_ok  = accept && (enc_err == 2'b00);
  assign accept_bad = accept && (enc_err != 2'b00);

  // Build the instruction word for the requested op and flag encodings that cannot be emitted.
  always_comb begin
    enc_word = 16'h0000;
    enc_err  = 2'b00;
    case (req_op)
      4'd0:    enc_word = {7'b0001100, req_rm, req_rn, req_rd};
      4'd1:    enc_word = {7'b0001110, req_imm[2:0], req_rn, req_rd};
      4'd2:    enc_word = {5'b00110, req_rd, req_imm[7:0]};
      4'd3:    enc_word = {7'b0001101, req_rm, req_rn, req_rd};
      4'd4:    enc_word = {7'b0001111, req_imm[2:0], req_rn, req_rd};
      4'd5:    enc_word = {5'b00111, req_rd, req_imm[7:0]};
      4'd6:    enc_word = {10'b0000000000, req_rm, req_rd};
      4'd7:    enc_word = {5'b00100, req_rd, req_imm[7:0]};
      4'd8:    enc_word = {5'b00000, req_imm[4:0], req_rm, req_rd};
      4'd9:    enc_word = {5'b00101, req_rn, req_imm[7:0]};
      4'd10:   enc_word = {10'b0100000001, req_rm, req_rd};
      4'd11:   enc_word = {5'b01101, req_imm[4:0], req_rn, req_rd};
      4'd12:   enc_word = {5'b01100, req_imm[4:0], req_rn, req_rd};
      4'd13:   enc_word = {5'b11100, req_imm};
      4'd14:   enc_word = {4'b1101, req_cond, req_imm[7:0]};
      default: enc_err  = 2'b01;
    endcase
`ifdef THUMB_ENC_RANGE_CHECK_EN
    // Ops without an immediate field ignore req_imm entirely; B uses all 11 bits.
    case (req_op)
      4'd1, 4'd4: if (|req_imm[10:3]) enc_err = 2'b10;
      4'd2, 4'd5, 4'd7, 4'd9: if (|req_imm[10:8]) enc_err = 2'b10;
      4'd8, 4'd11, 4'd12: if (|req_imm[10:5]) enc_err = 2'b10;
      4'd14: begin
        if (|req_imm[10:8]) enc_err = 2'b10;
        else if (req_cond[3:1] == 3'b111) enc_err = 2'b11;
      end
      default: ;
    endcase
`endif
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: a bad encoding parks in ERR, accepting the last address parks in FULL, rewind always resumes.
  always_comb begin
    state_d = state_q;
    if (rewind) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept_bad)                         state_d = ST_ERR;
          else if (accept_ok && ptr_q == LAST_ADDR) state_d = ST_FULL;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Write pipeline, address pointer, word count and sticky status; a latched write survives rewind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      ptr_q      <= '0;
      wdata_q    <= 16'h0000;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      we_q <= accept_ok;
      if (accept_ok) begin
        addr_q  <= ptr_q;
        wdata_q <= enc_word;
        ptr_q   <= ptr_q + ADDR_W'(1);
      end
      if (we_q) begin
        count_q <= count_q + (ADDR_W+1)'(1);
        if (addr_q == LAST_ADDR) full_q <= 1'b1;
      end
      if (accept_bad) begin
        err_q      <= 1'b1;
        err_code_q <= enc_err;
      end
      if (rewind) begin
        ptr_q      <= '0;
        count_q    <= '0;
        full_q     <= 1'b0;
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
